// File: rtl/taxi_eth_stat_accum_pkg.sv
// Shared types for the statistics accumulator: pipeline op codes, stage record, FSM states.
package taxi_eth_stat_accum_pkg;

   // Stage record fields are sized for the widest supported configuration.
   localparam int unsigned ADDR_MAX_W = 16;
   localparam int unsigned INC_MAX_W  = 32;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_INC,
      OP_RD
   } op_t;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   typedef struct packed {
      op_t                   op;
      logic [ADDR_MAX_W-1:0] addr;
      logic [INC_MAX_W-1:0]  inc;
   } stage_t;

endpackage

// File: rtl/taxi_axis_if.sv
// Minimal AXI-Stream interface carrying tdata/tid/tuser with valid/ready handshake.
interface taxi_axis_if #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned ID_W   = 8,
   parameter int unsigned USER_W = 1
);
   logic [DATA_W-1:0] tdata;
   logic [ID_W-1:0]   tid;
   logic [USER_W-1:0] tuser;
   logic              tvalid;
   logic              tready;

   modport src (output tdata, tid, tuser, tvalid, input tready);
   modport snk (input tdata, tid, tuser, tvalid, output tready);
endinterface

// File: rtl/taxi_eth_stat_accum_ram.sv
// Simple dual-port counter RAM: one write port, one read port with registered output.
module taxi_eth_stat_accum_ram #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Read-first: a same-edge write is not visible on rd_data_o until the next read.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
      rd_data_o <= mem[rd_addr_i];
   end

endmodule

// File: rtl/taxi_eth_stat_accum.sv
// MAC statistics accumulator: per-ID wide counters with a forwarded 3-stage RMW pipeline.
// Build option TAXI_ETH_STAT_ACCUM_CLEAR_ON_READ_EN makes host reads clear the counter.
module taxi_eth_stat_accum
   import taxi_eth_stat_accum_pkg::*;
#(
   parameter int unsigned STAT_INC_W = 24,
   parameter int unsigned STAT_ID_W  = 8,
   parameter int unsigned CNT_W      = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   taxi_axis_if.snk             s_axis_stat,
   input  logic                 rd_req,
   input  logic [STAT_ID_W-1:0] rd_addr,
   output logic                 rd_ack,
   output logic [CNT_W-1:0]     rd_data,
   output logic                 rd_valid,
   output logic                 init_done
);

   state_t                state_q;
   logic [STAT_ID_W-1:0]  init_addr_q;
   stage_t                s0, s1_q, s2_q;
   logic [CNT_W-1:0]      ram_rd_data;
   logic [CNT_W-1:0]      s1_old;
   logic [CNT_W-1:0]      s2_old_q;
   logic [CNT_W-1:0]      s2_result;
   logic                  s2_we;
   logic                  wr_en;
   logic [STAT_ID_W-1:0]  wr_addr;
   logic [CNT_W-1:0]      wr_data;
   logic                  byp_valid_q;
   logic [ADDR_MAX_W-1:0] byp_addr_q;
   logic [CNT_W-1:0]      byp_data_q;

   assign rd_ack             = (state_q == ST_RUN) && rd_req;
   assign s_axis_stat.tready = (state_q == ST_RUN) && !rd_req;

   // S0: host reads win; descriptor beats are consumed without touching the RAM.
   always_comb begin
      s0 = '0;
      if (rd_ack) begin
         s0.op   = OP_RD;
         s0.addr = ADDR_MAX_W'(rd_addr);
      end else if (s_axis_stat.tready && s_axis_stat.tvalid) begin
         s0.addr = ADDR_MAX_W'(s_axis_stat.tid[STAT_ID_W-1:0]);
         s0.inc  = INC_MAX_W'(s_axis_stat.tdata[STAT_INC_W-1:0]);
         if (!s_axis_stat.tuser[0]) begin
            s0.op = OP_INC;
         end
      end
   end

   // S1: the RAM cannot yet hold the op one ahead (in S2) nor the one written last edge.
   always_comb begin
      if ((s2_q.op != OP_NONE) && (s2_q.addr == s1_q.addr)) begin
         s1_old = s2_result;
      end else if (byp_valid_q && (byp_addr_q == s1_q.addr)) begin
         s1_old = byp_data_q;
      end else begin
         s1_old = ram_rd_data;
      end
   end

   always_comb begin
      s2_result = s2_old_q;
      s2_we     = 1'b0;
      case (s2_q.op)
         OP_INC: begin
            s2_result = s2_old_q + CNT_W'(s2_q.inc);
            s2_we     = 1'b1;
         end
`ifdef TAXI_ETH_STAT_ACCUM_CLEAR_ON_READ_EN
         OP_RD: begin
            s2_result = '0;
            s2_we     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      if (state_q == ST_INIT) begin
         wr_en   = 1'b1;
         wr_addr = init_addr_q;
         wr_data = '0;
      end else begin
         wr_en   = s2_we;
         wr_addr = s2_q.addr[STAT_ID_W-1:0];
         wr_data = s2_result;
      end
   end

   taxi_eth_stat_accum_ram #(
      .ADDR_W (STAT_ID_W),
      .DATA_W (CNT_W)
   ) u_ram (
      .clk_i     (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (s0.addr[STAT_ID_W-1:0]),
      .rd_data_o (ram_rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
         init_done   <= 1'b0;
         s1_q        <= '0;
         s2_q        <= '0;
         s2_old_q    <= '0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         byp_valid_q <= 1'b0;
         byp_addr_q  <= '0;
         byp_data_q  <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               init_addr_q <= init_addr_q + STAT_ID_W'(1);
               if (init_addr_q == '1) begin
                  state_q   <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            ST_RUN: ;
            default: state_q <= ST_INIT;
         endcase

         s1_q     <= s0;
         s2_q     <= s1_q;
         s2_old_q <= s1_old;

         rd_valid <= (s1_q.op == OP_RD);
         if (s1_q.op == OP_RD) begin
            rd_data <= s1_old;
         end

         byp_valid_q <= wr_en;
         byp_addr_q  <= ADDR_MAX_W'(wr_addr);
         byp_data_q  <= wr_data;
      end
   end

endmodule

// File: tb/tb_taxi_eth_stat_accum.sv
// Bench for taxi_eth_stat_accum: counter-array model with per-cycle compare plus directed reads.
module tb_taxi_eth_stat_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_req = 1'b0;
   logic [7:0]  rd_addr = '0;
   logic        rd_ack, rd_valid, init_done;
   logic [63:0] rd_data;

   logic        w_rd_req = 1'b0;
   logic [3:0]  w_rd_addr = '0;
   logic        w_rd_ack, w_rd_valid, w_init_done;
   logic [23:0] w_rd_data;

   int n_checks = 0;
   int n_errors = 0;

   taxi_axis_if #(.DATA_W(24), .ID_W(8), .USER_W(1)) s_axis ();
   taxi_axis_if #(.DATA_W(24), .ID_W(4), .USER_W(1)) w_axis ();

   taxi_eth_stat_accum dut (
      .clk         (clk),
      .rst         (rst),
      .s_axis_stat (s_axis),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_ack      (rd_ack),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .init_done   (init_done)
   );

   // Narrow instance so counter wrap is reachable with a couple of beats.
   taxi_eth_stat_accum #(.STAT_INC_W(24), .STAT_ID_W(4), .CNT_W(24)) dut_w (
      .clk         (clk),
      .rst         (rst),
      .s_axis_stat (w_axis),
      .rd_req      (w_rd_req),
      .rd_addr     (w_rd_addr),
      .rd_ack      (w_rd_ack),
      .rd_data     (w_rd_data),
      .rd_valid    (w_rd_valid),
      .init_done   (w_init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: counter array plus queue of read results, each due two cycles after its ack.
   typedef struct {
      int          due;
      logic [63:0] val;
   } exp_t;

   logic [63:0] model [256];
   exp_t        exp_q[$];
   int          ncnt = 0;
   int          init_left = 256;

   always @(negedge clk) begin : monitor
      bit busy;
      bit exp_v;
      ncnt++;
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == ncnt);
      check("mon_rd_valid", {63'd0, rd_valid}, {63'd0, exp_v});
      if (exp_v) begin
         check("mon_rd_data", rd_data, exp_q[0].val);
         void'(exp_q.pop_front());
      end
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < 256; i++) model[i] = '0;
         init_left = 256;
      end else begin
         busy = (init_left > 0);
         check("mon_tready", {63'd0, s_axis.tready}, {63'd0, !busy && !rd_req});
         check("mon_rd_ack", {63'd0, rd_ack}, {63'd0, !busy && rd_req});
         check("mon_init_done", {63'd0, init_done}, {63'd0, !busy});
         if (busy) begin
            init_left--;
         end else if (rd_req) begin
            exp_q.push_back('{due: ncnt + 2, val: model[rd_addr]});
`ifdef TAXI_ETH_STAT_ACCUM_CLEAR_ON_READ_EN
            model[rd_addr] = '0;
`endif
         end else if (s_axis.tvalid && !s_axis.tuser[0]) begin
            model[s_axis.tid] = model[s_axis.tid] + 64'(s_axis.tdata);
         end
      end
   end

   task automatic wait_init(input string name);
      int n;
      n = 0;
      while (!init_done && n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (n == 8) rd_req = 1'b0;
      end
      check(name, 64'(n), 64'd256);
   endtask

   task automatic send_beat(input logic [7:0] id, input logic [23:0] inc);
      int n;
      n = 0;
      s_axis.tvalid = 1'b1;
      s_axis.tid    = id;
      s_axis.tdata  = inc;
      s_axis.tuser  = 1'b0;
      @(negedge clk);
      while (!s_axis.tready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("beat_accept", {63'd0, s_axis.tready}, 64'd1);
      @(posedge clk); #1;
      s_axis.tvalid = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] id, input logic [63:0] exp, input string name);
      int n;
      n = 0;
      rd_req  = 1'b1;
      rd_addr = id;
      @(negedge clk);
      while (!rd_ack && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ack"}, {63'd0, rd_ack}, 64'd1);
      @(posedge clk); #1;
      rd_req = 1'b0;
      @(posedge clk); #1;
      check({name, "_valid"}, {63'd0, rd_valid}, 64'd1);
      check(name, rd_data, exp);
   endtask

   initial begin
      s_axis.tvalid = 1'b0; s_axis.tid = '0; s_axis.tdata = '0; s_axis.tuser = '0;
      w_axis.tvalid = 1'b0; w_axis.tid = '0; w_axis.tdata = '0; w_axis.tuser = '0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_rd_data", rd_data, 64'd0);
      check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      check("rst_init_done", {63'd0, init_done}, 64'd0);
      check("rst_tready", {63'd0, s_axis.tready}, 64'd0);
      // A read request held during the clear sweep must not be acked.
      rd_req = 1'b1;
      #0 check("init_rd_ack", {63'd0, rd_ack}, 64'd0);
      wait_init("init_cycles");

      do_read(8'd0, 64'd0, "rd_id0");
      do_read(8'd17, 64'd0, "rd_id17");
      do_read(8'd255, 64'd0, "rd_id255");

      // Back-to-back same-id increments, read immediately behind them.
      send_beat(8'd5, 24'd3);
      send_beat(8'd5, 24'd7);
      send_beat(8'd5, 24'hFFFFFF);
      do_read(8'd5, 64'h1000009, "rd_fwd_id5");

      // Same id two ops apart, with an unrelated beat between.
      send_beat(8'd7, 24'd5);
      send_beat(8'd8, 24'd1);
      send_beat(8'd7, 24'd6);
      do_read(8'd7, 64'd11, "rd_gap_id7");
      do_read(8'd8, 64'd1, "rd_id8");

      // Descriptor beat: accepted at once, no count.
      s_axis.tvalid = 1'b1; s_axis.tid = 8'd9; s_axis.tdata = 24'd100; s_axis.tuser = 1'b1;
      @(negedge clk);
      check("tuser_tready", {63'd0, s_axis.tready}, 64'd1);
      @(posedge clk); #1;
      s_axis.tvalid = 1'b0; s_axis.tuser = 1'b0;
      do_read(8'd9, 64'd0, "rd_tuser_id9");

      // Read and increment of the same id arrive together.
      send_beat(8'd3, 24'd10);
      rd_req = 1'b1; rd_addr = 8'd3;
      s_axis.tvalid = 1'b1; s_axis.tid = 8'd3; s_axis.tdata = 24'd4;
      @(negedge clk);
      check("coll_rd_ack", {63'd0, rd_ack}, 64'd1);
      check("coll_tready", {63'd0, s_axis.tready}, 64'd0);
      @(posedge clk); #1;
      rd_req = 1'b0;
      @(negedge clk);
      check("coll_tready_after", {63'd0, s_axis.tready}, 64'd1);
      @(posedge clk); #1;
      s_axis.tvalid = 1'b0;
      check("coll_rd_valid", {63'd0, rd_valid}, 64'd1);
      check("coll_rd_data", rd_data, 64'd10);
`ifdef TAXI_ETH_STAT_ACCUM_CLEAR_ON_READ_EN
      do_read(8'd3, 64'd4, "coll_next_read");
`else
      do_read(8'd3, 64'd14, "coll_next_read");
`endif

      // Wrap on the 24-bit instance: 0xFFFFFF + 2 = 1.
      check("w_init_done", {63'd0, w_init_done}, 64'd1);
      w_axis.tvalid = 1'b1; w_axis.tid = 4'd2; w_axis.tdata = 24'hFFFFFF;
      @(negedge clk);
      check("w_tready", {63'd0, w_axis.tready}, 64'd1);
      @(posedge clk); #1;
      w_axis.tdata = 24'd2;
      @(posedge clk); #1;
      w_axis.tvalid = 1'b0;
      w_rd_req = 1'b1; w_rd_addr = 4'd2;
      @(negedge clk);
      check("w_rd_ack", {63'd0, w_rd_ack}, 64'd1);
      @(posedge clk); #1;
      w_rd_req = 1'b0;
      @(posedge clk); #1;
      check("w_rd_valid", {63'd0, w_rd_valid}, 64'd1);
      check("w_wrap", {40'd0, w_rd_data}, 64'd1);

      // Reset in the middle of a burst with a read already acked.
      for (int i = 0; i < 6; i++) begin
         s_axis.tvalid = 1'b1; s_axis.tid = 8'(20 + i); s_axis.tdata = 24'(i + 1);
         @(posedge clk); #1;
      end
      rd_req = 1'b1; rd_addr = 8'd20;
      @(negedge clk);
      check("burst_rd_ack", {63'd0, rd_ack}, 64'd1);
      @(posedge clk); #1;
      rd_req = 1'b0; s_axis.tvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_drop_rd_valid", {63'd0, rd_valid}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_init("reinit_cycles");
      do_read(8'd20, 64'd0, "post_rst_id20");
      do_read(8'd25, 64'd0, "post_rst_id25");
      do_read(8'd5, 64'd0, "post_rst_id5");
      do_read(8'd3, 64'd0, "post_rst_id3");

      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
